// File: rtl/tensor_walk_sequencer.sv
// rtl/tensor_walk_sequencer.sv - expands one tensor descriptor into per-element rd/wr address beats
// Validates extents, then walks the source dims innermost-first with registered valid/ready output.
module tensor_walk_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 10,
  parameter int NDIM   = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [2*NDIM*DIM_W+2*ADDR_W+15:0] desc_tdata,
  input  logic                              desc_tvalid,
  output logic                              desc_tready,
  output logic [2*ADDR_W+9:0]               cmd_tdata,
  output logic                              cmd_tvalid,
  output logic                              cmd_tlast,
  input  logic                              cmd_tready,
  output logic                              done,
  output logic                              err,
  output logic                              busy
);

  localparam int DV     = NDIM * DIM_W;
  localparam int DESC_W = 2*DV + 2*ADDR_W + 16;
  localparam int IN_L   = 3;
  localparam int OUT_L  = 0;
  localparam int DA_L   = 6;
  localparam int SA_L   = DA_L + ADDR_W;
  localparam int DD_L   = SA_L + ADDR_W;
  localparam int SD_L   = DD_L + DV;
  localparam int SUB_L  = SD_L + DV;
  localparam int OP_L   = SUB_L + 5;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [DESC_W-1:0] r_desc;
  logic [DIM_W-1:0]  r_k      [NDIM];
  logic [DIM_W-1:0]  w_k_next [NDIM];
  logic [ADDR_W-1:0] r_rd, r_wr, w_rd_step, w_wr_step;
  logic [DV-1:0]     r_rem, w_s, w_d, w_src_dim, w_dst_dim;
  logic              r_valid, r_last, r_err, w_bad, w_carry, w_hs;

  assign w_src_dim = r_desc[SD_L +: DV];
  assign w_dst_dim = r_desc[DD_L +: DV];
  assign w_rd_step = ADDR_W'(1) << r_desc[IN_L +: 3];
  assign w_wr_step = ADDR_W'(1) << r_desc[OUT_L +: 3];
  assign w_hs      = r_valid & cmd_tready;

  assign cmd_tdata  = {r_desc[OP_L +: 5], r_desc[SUB_L +: 5], r_rd, r_wr};
  assign cmd_tvalid = r_valid;
  assign cmd_tlast  = r_last;
  assign err        = r_err;

  // Element counts of both sides; a zero extent or a count mismatch rejects the descriptor.
  always_comb begin
    w_s   = DV'(1);
    w_d   = DV'(1);
    w_bad = 1'b0;
    for (int k = 0; k < NDIM; k++) begin
      w_s = w_s * DV'(w_src_dim[k*DIM_W +: DIM_W]);
      w_d = w_d * DV'(w_dst_dim[k*DIM_W +: DIM_W]);
      if (w_src_dim[k*DIM_W +: DIM_W] == '0 || w_dst_dim[k*DIM_W +: DIM_W] == '0)
        w_bad = 1'b1;
    end
    if (w_s != w_d)
      w_bad = 1'b1;
  end

  // Ripple-carry walk over the source extents, k0 innermost.
  always_comb begin
    w_carry = 1'b1;
    for (int k = 0; k < NDIM; k++) begin
      w_k_next[k] = r_k[k];
      if (w_carry) begin
        if (r_k[k] == w_src_dim[k*DIM_W +: DIM_W] - 1'b1) begin
          w_k_next[k] = '0;
        end else begin
          w_k_next[k] = r_k[k] + 1'b1;
          w_carry     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    desc_tready = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        desc_tready = 1'b1;
        busy        = 1'b0;
        if (desc_tvalid) w_next = S_CHECK;
      end
      S_CHECK: w_next = w_bad ? S_DONE : S_RUN;
      S_RUN:   if (w_hs && r_last) w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_desc  <= '0;
      r_k     <= '{default: '0};
      r_rd    <= '0;
      r_wr    <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (desc_tvalid) r_desc <= desc_tdata;
        S_CHECK: begin
          if (w_bad) begin
            r_err <= 1'b1;
          end else begin
            r_k     <= '{default: '0};
            r_rd    <= r_desc[SA_L +: ADDR_W];
            r_wr    <= r_desc[DA_L +: ADDR_W];
            r_rem   <= w_s;
            r_last  <= (w_s == DV'(1));
            r_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_k    <= w_k_next;
            r_rd   <= r_rd + w_rd_step;
            r_wr   <= r_wr + w_wr_step;
            r_rem  <= r_rem - 1'b1;
            r_last <= (r_rem == DV'(2));
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_err   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_walk_sequencer.sv
// tb/tb_tensor_walk_sequencer.sv - self-checking bench for tensor_walk_sequencer
module tb_tensor_walk_sequencer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [117:0] desc_tdata = '0;
  logic         desc_tvalid = 1'b0;
  logic         desc_tready;
  logic [31:0]  cmd_tdata;
  logic         cmd_tvalid, cmd_tlast;
  logic         cmd_tready = 1'b1;
  logic         done, err, busy;

  tensor_walk_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .desc_tdata(desc_tdata), .desc_tvalid(desc_tvalid), .desc_tready(desc_tready),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tlast(cmd_tlast),
    .cmd_tready(cmd_tready), .done(done), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic        exp_err[$];
  logic [10:0] obs_rd[$];
  logic [10:0] obs_wr[$];
  logic        obs_last[$];
  int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_edge = 0;
  logic        tog = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(posedge clock) cyc <= cyc + 1;

  // Ready driver: held high, or toggled every cycle when tog is set.
  initial forever begin
    @(posedge clock);
    #1;
    if (tog) cmd_tready = ~cmd_tready;
    else     cmd_tready = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [117:0] mk(input logic [4:0] op, input logic [4:0] sub,
                                      input logic [39:0] sd, input logic [39:0] dd,
                                      input logic [10:0] sa, input logic [10:0] da,
                                      input logic [2:0] ins, input logic [2:0] outs);
    return {op, sub, sd, dd, sa, da, ins, outs};
  endfunction

  // Reference: element i reads src_addr + i*2^in_size and writes dstn_addr + i*2^out_size.
  function automatic void model(input logic [117:0] d);
    longint s, n;
    bit bad;
    s = 1; n = 1; bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (d[68+k*10 +: 10] == 0 || d[28+k*10 +: 10] == 0) bad = 1;
      s = s * longint'(d[68+k*10 +: 10]);
      n = n * longint'(d[28+k*10 +: 10]);
    end
    if (bad || s != n) begin
      exp_err.push_back(1'b1);
    end else begin
      for (longint i = 0; i < s; i++) begin
        beat_t b;
        b.data = {d[117:108], 11'(longint'(d[27:17]) + i * (longint'(1) << d[5:3])),
                              11'(longint'(d[16:6])  + i * (longint'(1) << d[2:0]))};
        b.last = (i == s - 1);
        exp_q.push_back(b);
      end
      exp_err.push_back(1'b0);
    end
  endfunction

  // Compare process: negedge view of what the next posedge will accept.
  always @(negedge clock) begin
    if (reset_n) begin
      if (stall_prev) begin
        chk("hold_valid", cmd_tvalid, 1'b1);
        chk("hold_data", cmd_tdata, prev_data);
        chk("hold_last", cmd_tlast, prev_last);
      end
      if (cmd_tvalid && cmd_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_beat: got data %0h expected no beat", cmd_tdata);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", cmd_tdata, b.data);
          chk("beat_last", cmd_tlast, b.last);
        end
        obs_rd.push_back(cmd_tdata[21:11]);
        obs_wr.push_back(cmd_tdata[10:0]);
        obs_last.push_back(cmd_tlast);
        if (cmd_tlast) last_edge = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_err.size() == 0) begin
          n_chk++;
          $display("FAIL extra_done: got done=1 err=%0d expected no done", err);
        end else begin
          chk("done_err", err, exp_err.pop_front());
        end
      end
      stall_prev = cmd_tvalid && !cmd_tready;
      prev_data  = cmd_tdata;
      prev_last  = cmd_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_logs();
    obs_rd.delete();
    obs_wr.delete();
    obs_last.delete();
  endtask

  task automatic send(input logic [117:0] d);
    int t = 0;
    while (!desc_tready && t < 100) begin
      @(posedge clock); #1; t++;
    end
    if (!desc_tready) begin
      n_chk++;
      $display("FAIL send_timeout: got desc_tready=0 expected 1");
    end
    desc_tdata  = d;
    desc_tvalid = 1'b1;
    model(d);
    @(posedge clock); #1;
    desc_tvalid = 1'b0;
    desc_tdata  = '1;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 300) begin
      @(posedge clock); #1; t++;
    end
    if (done_cnt < target) begin
      n_chk++;
      $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
    end
  endtask

  logic [117:0] d1, d3, d4, d5;
  int snap;

  initial begin
    d1 = mk(5'd3, 5'd9, {10'd1, 10'd1, 10'd2, 10'd4}, {10'd1, 10'd1, 10'd1, 10'd8},
            11'd10, 11'd100, 3'd0, 3'd1);
    d3 = mk(5'd4, 5'd1, {10'd1, 10'd1, 10'd2, 10'd4}, {10'd1, 10'd1, 10'd1, 10'd7},
            11'd10, 11'd100, 3'd0, 3'd1);
    d4 = mk(5'd5, 5'd2, {10'd1, 10'd0, 10'd2, 10'd4}, {10'd1, 10'd0, 10'd2, 10'd4},
            11'd0, 11'd0, 3'd0, 3'd0);
    d5 = mk(5'd1, 5'd2, {10'd1, 10'd1, 10'd1, 10'd3}, {10'd1, 10'd1, 10'd3, 10'd1},
            11'd2046, 11'd2047, 3'd1, 3'd0);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_desc_tready", desc_tready, 1'b1);
    chk("rst_cmd_tvalid", cmd_tvalid, 1'b0);
    chk("rst_cmd_tlast", cmd_tlast, 1'b0);
    chk("rst_cmd_tdata", cmd_tdata, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: back-to-back copy
    clear_logs();
    send(d1);
    chk("lat_n1_valid", cmd_tvalid, 1'b0);
    chk("check_tready", desc_tready, 1'b0);
    @(posedge clock); #1;
    chk("lat_n2_valid", cmd_tvalid, 1'b1);
    chk("run_busy", busy, 1'b1);
    wait_done(1);
    chk("t1_tready_after", desc_tready, 1'b1);
    chk("t1_beats", obs_rd.size(), 8);
    chk("t1_rd0", obs_rd[0], 11'd10);
    chk("t1_rd7", obs_rd[7], 11'd17);
    chk("t1_wr1", obs_wr[1], 11'd102);
    chk("t1_wr7", obs_wr[7], 11'd114);
    chk("t1_last6", obs_last[6], 1'b0);
    chk("t1_last7", obs_last[7], 1'b1);
    chk("t1_done_cycle", done_cyc, last_edge);
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: toggling ready
    clear_logs();
    tog = 1'b1;
    send(d1);
    wait_done(2);
    tog = 1'b0;
    chk("t2_beats", obs_rd.size(), 8);
    chk("t2_rd3", obs_rd[3], 11'd13);
    chk("t2_wr7", obs_wr[7], 11'd114);

    // 3: count mismatch, then a good descriptor
    @(posedge clock); #1;
    clear_logs();
    send(d3);
    @(posedge clock); #1;
    chk("t3_done", done, 1'b1);
    chk("t3_err", err, 1'b1);
    wait_done(3);
    chk("t3_beats", obs_rd.size(), 0);
    chk("t3_err_hold", err, 1'b1);
    send(d1);
    wait_done(4);
    chk("t3_next_err", err, 1'b0);
    chk("t3_next_beats", obs_rd.size(), 8);

    // 4: zero extent
    clear_logs();
    send(d4);
    wait_done(5);
    chk("t4_beats", obs_rd.size(), 0);
    chk("t4_err", err, 1'b1);

    // 5: address wrap
    clear_logs();
    send(d5);
    wait_done(6);
    chk("t5_rd0", obs_rd[0], 11'd2046);
    chk("t5_rd1", obs_rd[1], 11'd0);
    chk("t5_rd2", obs_rd[2], 11'd2);
    chk("t5_wr0", obs_wr[0], 11'd2047);
    chk("t5_wr1", obs_wr[1], 11'd0);
    chk("t5_wr2", obs_wr[2], 11'd1);
    chk("t5_last0", obs_last[0], 1'b0);
    chk("t5_last2", obs_last[2], 1'b1);

    // 6: reset mid-run after 3 beats
    clear_logs();
    send(d1);
    begin
      int t = 0;
      while (obs_rd.size() < 3 && t < 100) begin
        @(posedge clock); #1; t++;
      end
    end
    chk("t6_pre_beats", obs_rd.size(), 3);
    snap = done_cnt;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("t6_valid", cmd_tvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    exp_q.delete();
    exp_err.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t6_tready", desc_tready, 1'b1);
    chk("t6_no_done", done_cnt, snap);
    clear_logs();
    send(d1);
    wait_done(snap + 1);
    chk("t6_beats", obs_rd.size(), 8);
    chk("t6_rd0", obs_rd[0], 11'd10);
    chk("t6_wr0", obs_wr[0], 11'd100);
    chk("t6_q_empty", exp_q.size(), 0);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
